gate_sweep_checker: RTL and testbench



---
 rtl/gate_chk_pkg.sv | 10 +
 rtl/gate_golden.sv | 17 +
 rtl/gate_sweep_checker.sv | 98 +++++++++
 tb/tb_gate_sweep_checker.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/gate_chk_pkg.sv
// gate_chk_pkg: shared state encoding and response bit positions for the gate sweep checker
package gate_chk_pkg;
  typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_SETTLE, S_SAMPLE, S_DONE} state_t;
  localparam int NUM_VECTORS = 4;
  localparam int IDX_INV  = 4;
  localparam int IDX_AND  = 3;
  localparam int IDX_OR   = 2;
  localparam int IDX_XOR  = 1;
  localparam int IDX_NAND = 0;
endpackage

// File: rtl/gate_golden.sv
// gate_golden: expected five-gate response for one {a,b} input vector
module gate_golden
  import gate_chk_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  output logic [4:0] resp_o
);
  always_comb begin
    resp_o = '0;
    resp_o[IDX_INV]  = ~a_i;
    resp_o[IDX_AND]  = a_i & b_i;
    resp_o[IDX_OR]   = a_i | b_i;
    resp_o[IDX_XOR]  = a_i ^ b_i;
    resp_o[IDX_NAND] = ~(a_i & b_i);
  end
endmodule

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: walks {a,b} through 00..11, samples the gate outputs after a settle
// interval and accumulates sticky per-gate errors, a mismatch count and a pass flag.
module gate_sweep_checker
  import gate_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       tst_a,
  output logic       tst_b,
  input  logic [4:0] dut_resp,
  output logic [4:0] err_mask,
  output logic [2:0] err_count,
  output logic       pass
);
  localparam logic [1:0] LAST_IDX = 2'(NUM_VECTORS - 1);
  localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);
  state_t     state_q;
  logic [3:0] cnt_q;
  logic [1:0] idx_q;
  logic       busy_q, done_q, tst_a_q, tst_b_q, pass_q;
  logic [4:0] err_mask_q, golden, mism_d;
  logic [2:0] err_count_q, err_count_d;
  // Golden follows the index, which is stable from DRIVE through SAMPLE
  gate_golden u_golden (
    .a_i    (idx_q[1]),
    .b_i    (idx_q[0]),
    .resp_o (golden)
  );
  assign mism_d      = dut_resp ^ golden;
  assign err_count_d = err_count_q + {2'b00, |mism_d};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tst_a_q     <= 1'b0;
      tst_b_q     <= 1'b0;
      pass_q      <= 1'b0;
      err_mask_q  <= '0;
      err_count_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          state_q     <= S_DRIVE;
          busy_q      <= 1'b1;
          idx_q       <= '0;
          err_mask_q  <= '0;
          err_count_q <= '0;
          pass_q      <= 1'b0;
        end
        S_DRIVE: begin
          tst_a_q <= idx_q[1];
          tst_b_q <= idx_q[0];
          cnt_q   <= '0;
          state_q <= (SETTLE_CYCLES > 0) ? S_SETTLE : S_SAMPLE;
        end
        S_SETTLE: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == LAST_CNT) state_q <= S_SAMPLE;
        end
        S_SAMPLE: begin
          err_mask_q  <= err_mask_q | mism_d;
          err_count_q <= err_count_d;
          if (idx_q != LAST_IDX) begin
            idx_q   <= idx_q + 2'd1;
            state_q <= S_DRIVE;
          end else begin
            state_q <= S_DONE;
            tst_a_q <= 1'b0;
            tst_b_q <= 1'b0;
            pass_q  <= (err_count_d == 3'd0);
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign busy      = busy_q;
  assign done      = done_q;
  assign tst_a     = tst_a_q;
  assign tst_b     = tst_b_q;
  assign err_mask  = err_mask_q;
  assign err_count = err_count_q;
  assign pass      = pass_q;
endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb_gate_sweep_checker: two checkers (settle 2 and settle 0) driving modelled gates with
// injectable faults; results are predicted by sweeping the four vectors in plain code.
module tb_gate_sweep_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic st[2];
  logic by[2], dn[2], ta[2], tb[2], ps[2];
  logic [4:0] rsp[2], em[2];
  logic [2:0] ec[2];
  int mode[2];
  logic [4:0] flip[2][4];
  logic ga, gb;
  logic [4:0] gr;
  int n_chk = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  function automatic logic [4:0] ideal(logic a, logic b);
    return {~a, a & b, a | b, a ^ b, ~(a & b)};
  endfunction
  // Faulty gate behaviour: 1 AND stuck 0, 2 OR/XOR swapped, 3 inverter as buffer, 4 random flips
  function automatic logic [4:0] gates(int m, logic [4:0] rnd, logic a, logic b);
    logic [4:0] r;
    r = ideal(a, b);
    case (m)
      1: r[3] = 1'b0;
      2: r = {r[4:3], r[1], r[2], r[0]};
      3: r[4] = a;
      4: r = r ^ rnd;
      default: ;
    endcase
    return r;
  endfunction
  assign rsp[0] = gates(mode[0], flip[0][{ta[0], tb[0]}], ta[0], tb[0]);
  assign rsp[1] = gates(mode[1], flip[1][{ta[1], tb[1]}], ta[1], tb[1]);
  gate_sweep_checker #(.SETTLE_CYCLES(2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .busy(by[0]), .done(dn[0]),
    .tst_a(ta[0]), .tst_b(tb[0]), .dut_resp(rsp[0]), .err_mask(em[0]),
    .err_count(ec[0]), .pass(ps[0])
  );
  gate_sweep_checker #(.SETTLE_CYCLES(0)) u_s0 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .busy(by[1]), .done(dn[1]),
    .tst_a(ta[1]), .tst_b(tb[1]), .dut_resp(rsp[1]), .err_mask(em[1]),
    .err_count(ec[1]), .pass(ps[1])
  );
  gate_golden u_gold (.a_i(ga), .b_i(gb), .resp_o(gr));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic predict(input int d, output logic [4:0] pm, output int pc);
    logic [1:0] v;
    logic [4:0] m;
    pm = '0;
    pc = 0;
    for (int i = 0; i < 4; i++) begin
      v = 2'(i);
      m = gates(mode[d], flip[d][i], v[1], v[0]) ^ ideal(v[1], v[0]);
      pm |= m;
      if (m != 0) pc++;
    end
  endtask
  task automatic sweep(input int d, input bit mid_start);
    logic [4:0] pm;
    int pc, k, lat;
    lat = (d == 0) ? 16 : 8;
    predict(d, pm, pc);
    @(posedge clk); #1 st[d] = 1'b1;
    @(posedge clk); #1 st[d] = 1'b0;
    chk("busy_rise", by[d], 1);
    k = 0;
    while (!dn[d] && k < 60) begin
      @(posedge clk); #1 k++;
      if (mid_start && k == 3) st[d] = 1'b1;
      if (mid_start && k == 4) st[d] = 1'b0;
    end
    chk("done_latency", k, lat);
    chk("busy_in_done", by[d], 1);
    chk("err_mask", em[d], pm);
    chk("err_count", ec[d], pc);
    chk("pass", ps[d], pc == 0);
    chk("tst_idle", {ta[d], tb[d]}, 0);
    @(posedge clk); #1;
    chk("done_pulse", dn[d], 0);
    chk("busy_fall", by[d], 0);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_mask", em[d], pm);
    chk("hold_count", ec[d], pc);
    chk("hold_pass", ps[d], pc == 0);
  endtask
  initial begin
    int k, nd, first, second;
    st[0] = 1'b0; st[1] = 1'b0; mode[0] = 0; mode[1] = 0;
    for (int d = 0; d < 2; d++) for (int v = 0; v < 4; v++) flip[d][v] = '0;
    for (int i = 0; i < 4; i++) begin
      {ga, gb} = 2'(i);
      #1 chk("golden", gr, ideal(ga, gb));
    end
    #20;
    for (int d = 0; d < 2; d++)
      chk("reset_outs", {by[d], dn[d], ta[d], tb[d], em[d], ec[d], ps[d]}, 0);
    @(negedge clk) rst_n = 1'b1;
    mode[0] = 0; sweep(0, 0);
    mode[0] = 1; sweep(0, 0);
    mode[0] = 2; sweep(0, 1);
    mode[1] = 3; sweep(1, 0);
    mode[1] = 0; sweep(1, 1);
    // Abort a faulty sweep while vector 10 is on the gate inputs
    mode[0] = 3;
    @(posedge clk); #1 st[0] = 1'b1;
    @(posedge clk); #1 st[0] = 1'b0;
    k = 0;
    while (!(ta[0] && !tb[0]) && k < 40) begin
      @(posedge clk); #1 k++;
    end
    chk("reach_vec10", {ta[0], tb[0]}, 2'b10);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {by[0], dn[0], ta[0], tb[0], em[0], ec[0], ps[0]}, 0);
    @(negedge clk) rst_n = 1'b1;
    nd = 0;
    repeat (30) begin
      @(posedge clk); #1 if (dn[0]) nd++;
    end
    chk("no_done_after_abort", nd, 0);
    mode[0] = 0; sweep(0, 0);
    // start held for 40 cycles: done at 17 and 35 counted from the first sampled edge
    @(posedge clk); #1 st[0] = 1'b1;
    nd = 0; first = 0; second = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (dn[0]) begin
        nd++;
        if (nd == 1) first = i;
        if (nd == 2) second = i;
      end
    end
    st[0] = 1'b0;
    chk("held_done_cycles", nd, 2);
    chk("held_first_done", first, 17);
    chk("held_second_done", second, 35);
    k = 0;
    while (by[0] && k < 40) begin
      @(posedge clk); #1 k++;
    end
    chk("held_drain", by[0], 0);
    chk("held_pass", ps[0], 1);
    for (int it = 0; it < 10; it++) begin
      int d;
      d = it % 2;
      mode[d] = int'($urandom_range(0, 4));
      for (int v = 0; v < 4; v++) flip[d][v] = ($urandom % 2 == 0) ? 5'($urandom) : 5'd0;
      sweep(d, it % 3 == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
